// File: rtl/io_timer_bank.sv
// Programmable prescaler, free-running tick-time register and NCH down-count
// timer channels with per-channel pending/enable bits and one interrupt line.
module io_timer_bank #(
  parameter int unsigned DIV = 25000,
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  adr,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tick,
  output logic        irq
);

  localparam int unsigned PW = $clog2(DIV);

  logic [PW-1:0]  pcnt;
  logic [CW-1:0]  tm;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] armed;
  logic [NCH-1:0] periodic;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] wr_rel;
  logic [NCH-1:0] wr_mode;
  logic [CW-1:0]  count  [NCH];
  logic [CW-1:0]  reload [NCH];
  logic           wr_en;
  logic           unused_bus;

  assign wr_en      = sel & wr;
  assign unused_bus = ^{rd, wdata};

  always_comb begin
    tick    = (pcnt == PW'(DIV - 1));
    wr_rel  = '0;
    wr_mode = '0;
    fire    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      wr_rel[k]  = wr_en && (adr == 4'(4 + 2 * k));
      wr_mode[k] = wr_en && (adr == 4'(5 + 2 * k));
      // A RELOAD write on the same edge suppresses the fire entirely.
      fire[k]    = tick && armed[k] && !wr_rel[k] && (count[k] == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt     <= '0;
      tm       <= '0;
      pending  <= '0;
      enable   <= '0;
      armed    <= '0;
      periodic <= '0;
      irq      <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        count[k]  <= '0;
        reload[k] <= '0;
      end
    end else begin
      if (wr_en && adr == 4'd0) begin
        tm   <= wdata[CW-1:0];
        pcnt <= '0;
      end else begin
        pcnt <= tick ? '0 : pcnt + PW'(1);
        if (tick)
          tm <= tm + CW'(1);
      end

      // Set wins over a same-cycle write-1 clear.
      if (wr_en && adr == 4'd1)
        pending <= (pending & ~wdata[NCH-1:0]) | fire;
      else
        pending <= pending | fire;

      if (wr_en && adr == 4'd2)
        enable <= wdata[NCH-1:0];

      irq <= |(pending & enable);

      for (int unsigned k = 0; k < NCH; k++) begin
        if (wr_rel[k]) begin
          reload[k] <= wdata[CW-1:0];
          count[k]  <= wdata[CW-1:0];
          armed[k]  <= (wdata[CW-1:0] != '0);
        end else if (tick && armed[k]) begin
          if (count[k] > CW'(1)) begin
            count[k] <= count[k] - CW'(1);
          end else if (fire[k]) begin
            if (periodic[k]) begin
              count[k] <= reload[k];
            end else begin
              count[k] <= '0;
              armed[k] <= 1'b0;
            end
          end
        end
        if (wr_mode[k])
          periodic[k] <= wdata[0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (adr)
        4'd0: rdata = 32'(tm);
        4'd1: rdata = 32'(pending);
        4'd2: rdata = 32'(enable);
        default: begin
          for (int unsigned k = 0; k < NCH; k++) begin
            if (adr == 4'(4 + 2 * k))
              rdata = 32'(reload[k]);
            if (adr == 4'(5 + 2 * k))
              rdata = 32'({count[k], armed[k], periodic[k]});
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer_bank.sv
// Directed plus randomized bench for io_timer_bank against a tick-arithmetic
// reference model; every register is swept after each clock edge.
module tb_io_timer_bank;

  localparam int unsigned DIV = 4;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        wr  = 1'b0;
  logic        rd  = 1'b0;
  logic [3:0]  adr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tick;
  logic        irq;

  io_timer_bank #(.DIV(DIV), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .sel(sel), .adr(adr), .wr(wr), .rd(rd),
    .wdata(wdata), .rdata(rdata), .tick(tick), .irq(irq)
  );

  always #20 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: time is derived from an anchor (last write/reset) and
  // elapsed edges; channels hold "ticks remaining until fire".
  longint      cyc = 0;
  longint      anc_cyc = 0;
  logic [31:0] anc_time = '0;
  logic [3:0]  m_pend = '0;
  logic [3:0]  m_enab = '0;
  logic        m_irq = 1'b0;
  logic [31:0] m_cnt [4];
  logic [31:0] m_rel [4];
  logic        m_per [4];
  logic        m_arm [4];

  function automatic logic [31:0] m_time();
    return anc_time + 32'((cyc - anc_cyc) / longint'(DIV));
  endfunction

  function automatic logic m_tick();
    return ((cyc - anc_cyc) % longint'(DIV)) == longint'(DIV - 1);
  endfunction

  function automatic logic [31:0] m_rd(input int a);
    int k;
    if (a == 0) return m_time();
    if (a == 1) return {28'b0, m_pend};
    if (a == 2) return {28'b0, m_enab};
    if (a >= 4 && a < 4 + 2 * int'(NCH)) begin
      k = (a - 4) / 2;
      if (a % 2 == 0) return m_rel[k];
      return {m_cnt[k][29:0], m_arm[k], m_per[k]};
    end
    return 32'b0;
  endfunction

  task automatic model_edge(input logic s, input logic w, input logic [3:0] a,
                            input logic [31:0] d);
    logic       tk;
    logic       we;
    logic [3:0] np;
    if (rst) begin
      anc_time = '0;
      anc_cyc  = cyc + 1;
      m_pend   = '0;
      m_enab   = '0;
      m_irq    = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_cnt[k] = '0; m_rel[k] = '0; m_per[k] = 1'b0; m_arm[k] = 1'b0;
      end
    end else begin
      tk = m_tick();
      we = s & w;
      m_irq = |(m_pend & m_enab);
      np = m_pend;
      if (we && a == 4'd1) np = np & ~d[3:0];
      for (int k = 0; k < 4; k++) begin
        if (we && a == 4'(4 + 2 * k)) begin
          m_rel[k] = d; m_cnt[k] = d; m_arm[k] = (d != 0);
        end else if (tk && m_arm[k]) begin
          if (m_cnt[k] == 1) begin
            np[k] = 1'b1;
            if (m_per[k]) m_cnt[k] = m_rel[k];
            else begin m_cnt[k] = 0; m_arm[k] = 1'b0; end
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
        if (we && a == 4'(5 + 2 * k)) m_per[k] = d[0];
      end
      m_pend = np;
      if (we && a == 4'd2) m_enab = d[3:0];
      if (we && a == 4'd0) begin
        anc_time = d;
        anc_cyc  = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("tick", {31'b0, tick}, {31'b0, m_tick()});
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    sel = 1'b1; wr = 1'b0; rd = 1'b1;
    for (int a = 0; a < 16; a++) begin
      adr = 4'(a);
      #1;
      check($sformatf("rd%0d", a), rdata, m_rd(a));
    end
    sel = 1'b0; rd = 1'b0;
    #1;
    check("rd_nosel", rdata, 32'b0);
  endtask

  task automatic step(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
    sel = s; wr = w; adr = a; wdata = d; rd = s & ~w;
    @(posedge clk);
    model_edge(s, w, a, d);
    #2;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic wreg(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rdreg(input logic [3:0] a, output logic [31:0] v);
    sel = 1'b1; wr = 1'b0; adr = a;
    #1;
    v = rdata;
    sel = 1'b0;
  endtask

  // Idle until the next edge will be a tick edge (bounded by DIV).
  task automatic align_tick();
    for (int i = 0; i < int'(DIV) && !m_tick(); i++) idle(1);
  endtask

  logic [31:0] v;
  int          r;
  logic [3:0]  ra;
  logic [31:0] rdv;

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = '0; m_rel[k] = '0; m_per[k] = 1'b0; m_arm[k] = 1'b0;
    end

    // Reset, then free-run: tick at cycles 3,7,..., time = 10 after 40 cycles.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      idle(1);
      check("tick_seq", {31'b0, tick}, {31'b0, logic'(i % 4 == 3)});
    end
    rdreg(4'd0, v);
    check("time_after_40", v, 32'd10);

    // Channel 0 one-shot, reload 3.
    wreg(4'd2, 32'd1);
    wreg(4'd5, 32'd0);
    wreg(4'd4, 32'd3);
    idle(80);
    rdreg(4'd1, v);
    check("ch0_pend", v, 32'd1);
    rdreg(4'd5, v);
    check("ch0_mode_done", v, 32'd0);
    check("ch0_irq", {31'b0, irq}, 32'd1);

    // Channel 1 periodic, reload 2, cleared between fires.
    wreg(4'd1, 32'hF);
    wreg(4'd2, 32'd3);
    wreg(4'd7, 32'd1);
    wreg(4'd6, 32'd2);
    idle(10);
    wreg(4'd1, 32'd2);
    idle(12);
    rdreg(4'd1, v);
    check("ch1_refire", v & 32'd2, 32'd2);

    // PEND clear on the same edge as a ch0 fire: set wins.
    wreg(4'd7, 32'd0);
    wreg(4'd1, 32'hF);
    wreg(4'd4, 32'd1);
    align_tick();
    wreg(4'd1, 32'd1);
    rdreg(4'd1, v);
    check("pend_set_wins", v & 32'd1, 32'd1);

    // RELOAD write on a tick edge: loaded, no decrement.
    align_tick();
    wreg(4'd8, 32'd5);
    rdreg(4'd9, v);
    check("reload_on_tick", v, 32'd22);

    // TIME wrap and DIV-cycle restart.
    wreg(4'd0, 32'hFFFF_FFFF);
    idle(int'(DIV) - 1);
    rdreg(4'd0, v);
    check("time_pre_wrap", v, 32'hFFFF_FFFF);
    check("tick_after_write", {31'b0, tick}, 32'd1);
    idle(1);
    rdreg(4'd0, v);
    check("time_wrap", v, 32'd0);

    // TIME write on a tick edge: written value wins.
    align_tick();
    wreg(4'd0, 32'h100);
    rdreg(4'd0, v);
    check("time_write_on_tick", v, 32'h100);

    // Randomized bus traffic.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        ra = 4'($urandom_range(0, 15));
        if (ra >= 4'd4 && ra[0] == 1'b0) rdv = 32'($urandom_range(0, 6));
        else rdv = $urandom;
        wreg(ra, rdv);
      end else begin
        idle(1);
      end
    end

    // Reset mid-count with ch2 periodic and pending.
    wreg(4'd1, 32'hF);
    wreg(4'd2, 32'hF);
    wreg(4'd9, 32'd1);
    wreg(4'd8, 32'd3);
    idle(16);
    rdreg(4'd1, v);
    check("ch2_pend_before_rst", v & 32'd4, 32'd4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("irq_after_rst", {31'b0, irq}, 32'd0);
    rdreg(4'd1, v);
    check("pend_after_rst", v, 32'd0);
    rdreg(4'd13, v);
    check("rd13_zero", v, 32'd0);
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
